// File: rtl/half_pkg.sv
// Shared fp16 types and constants for the half-precision adder and its request arbiter.
// Pure declarations: no latency, no flow control.
package half_pkg;
    typedef logic [15:0] half_t;

    localparam half_t HALF_ZERO    = 16'h0000;
    localparam half_t HALF_ONE     = 16'h3C00;
    localparam half_t HALF_QNAN    = 16'h7E00;
    localparam int    HALF_ADD_LAT = 1;
endpackage

// File: rtl/half_add.sv
// fp16 adder, round-to-nearest-even, subnormal aware; result registered (1 cycle).
// No backpressure: the output register only loads when in_valid is high.
module half_add
    import half_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  logic  in_valid,
    input  half_t a,
    input  half_t b,
    output half_t c
);

    logic        sa, sb, s_big, a_big, sticky, rnd_up;
    logic [4:0]  ea, eb, eae, ebe, e_big, e_sml, ediff, lsh;
    logic [10:0] ma, mb;
    logic [13:0] m_big, m_sml, m_sh, norm;
    logic [14:0] sum;
    logic [5:0]  e_norm, e_fin;
    logic [11:0] mant_r;
    int          msb;
    half_t       c_d, c_q;

    always_comb begin
        sa     = a[15];
        sb     = b[15];
        ea     = a[14:10];
        eb     = b[14:10];
        ma     = {|ea, a[9:0]};
        mb     = {|eb, b[9:0]};
        eae    = (ea == 5'd0) ? 5'd1 : ea;
        ebe    = (eb == 5'd0) ? 5'd1 : eb;
        a_big  = (a[14:0] >= b[14:0]);
        s_big  = a_big ? sa : sb;
        e_big  = a_big ? eae : ebe;
        e_sml  = a_big ? ebe : eae;
        m_big  = a_big ? {ma, 3'b000} : {mb, 3'b000};
        m_sml  = a_big ? {mb, 3'b000} : {ma, 3'b000};
        ediff  = e_big - e_sml;
        m_sh   = '0;
        sticky = 1'b0;
        lsh    = '0;
        norm   = '0;
        e_norm = '0;
        msb    = 0;
        c_d    = HALF_ZERO;

        // Align the smaller operand, folding shifted-out bits into a sticky LSB.
        if (ediff > 5'd13) begin
            sticky = |m_sml;
        end else begin
            m_sh   = m_sml >> ediff;
            sticky = |(m_sml & ~(14'h3FFF << ediff));
        end
        m_sh[0] = m_sh[0] | sticky;

        sum = (sa == sb) ? ({1'b0, m_big} + {1'b0, m_sh}) : ({1'b0, m_big} - {1'b0, m_sh});

        for (int i = 0; i < 14; i++) begin
            if (sum[i]) msb = i;
        end

        if (sum[14]) begin
            norm   = sum[14:1] | {13'd0, sum[0]};
            e_norm = {1'b0, e_big} + 6'd1;
        end else begin
            // Left shift stops at exponent 1 so tiny results fall into the subnormal range.
            lsh    = (5'(13 - msb) < (e_big - 5'd1)) ? 5'(13 - msb) : (e_big - 5'd1);
            norm   = sum[13:0] << lsh;
            e_norm = {1'b0, e_big - lsh};
        end

        rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant_r = {1'b0, norm[13:3]} + {11'd0, rnd_up};
        e_fin  = e_norm;
        if (mant_r[11]) begin
            mant_r = mant_r >> 1;
            e_fin  = e_norm + 6'd1;
        end

        if (ea == 5'h1F || eb == 5'h1F) begin
            if ((ea == 5'h1F && a[9:0] != 10'd0) || (eb == 5'h1F && b[9:0] != 10'd0) ||
                (ea == 5'h1F && eb == 5'h1F && sa != sb))
                c_d = HALF_QNAN;
            else
                c_d = (ea == 5'h1F) ? a : b;
        end else if (sum == 15'd0) begin
            c_d = {sa & sb, 15'd0};
        end else if (e_fin >= 6'd31) begin
            c_d = {s_big, 5'h1F, 10'd0};
        end else begin
            c_d = {s_big, (mant_r[10] ? e_fin[4:0] : 5'd0), mant_r[9:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn)
            c_q <= HALF_ZERO;
        else if (in_valid)
            c_q <= c_d;
    end

    assign c = c_q;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from req, pointer advances past the winner.
// No backpressure of its own; adv low freezes the pointer.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             adv,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam int CW = IDX_W + 1;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CW-1:0]    cand_sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt      = '0;
        gnt_idx  = '0;
        ptr_d    = ptr_q;
        cand_sum = '0;
        cand     = '0;
        // Walk from farthest to nearest so the last hit is the first requester after ptr.
        for (int off = N - 1; off >= 0; off--) begin
            cand_sum = {1'b0, ptr_q} + CW'(off);
            if (cand_sum >= CW'(N))
                cand_sum = cand_sum - CW'(N);
            cand = cand_sum[IDX_W-1:0];
            if (req[cand]) begin
                gnt       = '0;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (adv && |gnt)
            ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/half_add_arbiter.sv
// Shares one fp16 adder among NUM_REQ requesters; grant to resp_valid is ADD_LAT+1 cycles.
// A requester holds one op at a time; its slot stays busy until resp_ready drains its buffer.
module half_add_arbiter
    import half_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = HALF_ADD_LAT,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*16-1:0] req_a,
    input  logic [NUM_REQ*16-1:0] req_b,
    output logic [NUM_REQ-1:0]    resp_valid,
    input  logic [NUM_REQ-1:0]    resp_ready,
    output logic [NUM_REQ*16-1:0] resp_c,
    output logic [IDX_W:0]        inflight,
    output logic [IDX_W-1:0]      grant_idx
);

    logic [NUM_REQ-1:0] busy_q, busy_d, elig, consume;
    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    half_t              resp_c_q [NUM_REQ];
    half_t              resp_c_d [NUM_REQ];
    half_t              in_a     [NUM_REQ];
    half_t              in_b     [NUM_REQ];
    logic               tag_vld_q [ADD_LAT];
    logic               tag_vld_d [ADD_LAT];
    logic [IDX_W-1:0]   tag_idx_q [ADD_LAT];
    logic [IDX_W-1:0]   tag_idx_d [ADD_LAT];
    logic [IDX_W:0]     inflight_q, inflight_d;
    logic               issue;
    half_t              op_a, op_b, core_c;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign in_a[g]            = req_a[16*g +: 16];
        assign in_b[g]            = req_b[16*g +: 16];
        assign resp_c[16*g +: 16] = resp_c_q[g];
    end

    // Slots freed this cycle are still marked busy, keeping resp_ready off the req_ready path.
    assign consume = resp_valid_q & resp_ready;
    assign elig    = req_valid & ~busy_q & {NUM_REQ{~rst}};
    assign issue   = |req_ready;

    rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (elig),
        .adv     (issue),
        .gnt     (req_ready),
        .gnt_idx (grant_idx)
    );

    always_comb begin
        op_a = HALF_ZERO;
        op_b = HALF_ZERO;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (issue && grant_idx == IDX_W'(i)) begin
                op_a = in_a[i];
                op_b = in_b[i];
            end
        end
    end

    // ADD_LAT must equal the core's fixed latency so tags line up with results.
    half_add u_core (
        .clk      (clk),
        .rstn     (~rst),
        .in_valid (issue),
        .a        (op_a),
        .b        (op_b),
        .c        (core_c)
    );

    always_comb begin
        tag_vld_d[0] = issue;
        tag_idx_d[0] = grant_idx;
        for (int s = 1; s < ADD_LAT; s++) begin
            tag_vld_d[s] = tag_vld_q[s-1];
            tag_idx_d[s] = tag_idx_q[s-1];
        end
    end

    always_comb begin
        busy_d       = (busy_q & ~consume) | req_ready;
        resp_valid_d = resp_valid_q & ~consume;
        resp_c_d     = resp_c_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (tag_vld_q[ADD_LAT-1] && tag_idx_q[ADD_LAT-1] == IDX_W'(i)) begin
                resp_valid_d[i] = 1'b1;
                resp_c_d[i]     = core_c;
            end
        end
        inflight_d = '0;
        for (int i = 0; i < NUM_REQ; i++)
            inflight_d = inflight_d + {IDX_W'(0), busy_d[i]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            resp_valid_q <= '0;
            inflight_q   <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                resp_c_q[i] <= HALF_ZERO;
            for (int s = 0; s < ADD_LAT; s++) begin
                tag_vld_q[s] <= 1'b0;
                tag_idx_q[s] <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            inflight_q   <= inflight_d;
            resp_c_q     <= resp_c_d;
            for (int s = 0; s < ADD_LAT; s++) begin
                tag_vld_q[s] <= tag_vld_d[s];
                tag_idx_q[s] <= tag_idx_d[s];
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign inflight   = inflight_q;

endmodule

// File: tb/tb_half_add_arbiter.sv
// Bench for half_add_arbiter: directed scenarios plus random traffic against a slot-level model.
module tb_half_add_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [N*16-1:0] req_a, req_b, resp_c;
    logic [IW:0]     inflight;
    logic [IW-1:0]   grant_idx;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    half_add_arbiter #(.NUM_REQ(N), .ADD_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_c     (resp_c),
        .inflight   (inflight),
        .grant_idx  (grant_idx)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, want);
        end
    endtask

    function automatic logic [15:0] int_to_half(input int v);
        int mag, e;
        logic [15:0] h;
        if (v == 0) return 16'h0000;
        mag = (v < 0) ? -v : v;
        e = 0;
        while ((mag >> (e + 1)) != 0) e++;
        h[15]    = (v < 0);
        h[14:10] = 5'(15 + e);
        h[9:0]   = 10'((mag << (10 - e)) & 32'h3FF);
        return h;
    endfunction

    function automatic int half_to_int(input logic [15:0] h);
        int e, m, v;
        e = int'(h[14:10]);
        if (e == 0) return 0;
        m = 1024 + int'(h[9:0]);
        v = (e >= 25) ? (m << (e - 25)) : (m >> (25 - e));
        return h[15] ? -v : v;
    endfunction

    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        return int_to_half(half_to_int(a) + half_to_int(b));
    endfunction

    // Slot-level model: each slot is idle or holds one op that becomes visible 2 cycles after grant.
    bit          m_busy [N];
    int          m_done [N];
    logic [15:0] m_pend [N];
    logic [15:0] m_buf  [N];
    int          m_ptr = 0;
    int          cyc   = 0;
    bit          known = 0;

    initial begin
        logic [N-1:0] e_rv, e_rdy;
        int e_gnt, cnt, k;
        forever begin
            @(negedge clk);
            cyc++;
            e_rv  = '0;
            e_rdy = '0;
            e_gnt = -1;
            cnt   = 0;
            for (int i = 0; i < N; i++) begin
                if (m_busy[i] && cyc == m_done[i]) m_buf[i] = m_pend[i];
                e_rv[i] = m_busy[i] && (cyc >= m_done[i]);
                cnt += int'(m_busy[i]);
            end
            if (!rst) begin
                for (int off = 0; off < N && e_gnt < 0; off++) begin
                    k = (m_ptr + off) % N;
                    if (req_valid[k] && !m_busy[k]) e_gnt = k;
                end
            end
            if (e_gnt >= 0) e_rdy[e_gnt] = 1'b1;

            if (known) begin
                chk("req_ready", 32'(req_ready), 32'(e_rdy));
                if (e_gnt >= 0) chk("grant_idx", 32'(grant_idx), e_gnt);
                chk("resp_valid", 32'(resp_valid), 32'(e_rv));
                chk("inflight", 32'(inflight), cnt);
                for (int i = 0; i < N; i++)
                    chk($sformatf("resp_c[%0d]", i), 32'(resp_c[16*i +: 16]), 32'(m_buf[i]));
                chk("grant_into_full_slot", 32'(req_ready & resp_valid), 0);
            end

            if (rst) begin
                for (int i = 0; i < N; i++) begin
                    m_busy[i] = 0;
                    m_buf[i]  = 16'h0000;
                end
                m_ptr = 0;
                known = 1;
            end else begin
                for (int i = 0; i < N; i++)
                    if (e_rv[i] && resp_ready[i]) m_busy[i] = 0;
                if (e_gnt >= 0) begin
                    m_busy[e_gnt] = 1;
                    m_done[e_gnt] = cyc + 2;
                    m_pend[e_gnt] = ref_add(req_a[16*e_gnt +: 16], req_b[16*e_gnt +: 16]);
                    m_ptr = (e_gnt + 1) % N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    function automatic logic [15:0] rnd_half();
        return int_to_half(int'($urandom_range(16, 0)) - 8);
    endfunction

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int n_g;
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        req_a      = '0;
        req_b      = '0;
        repeat (2) tick();
        rst = 1'b0;
        mid();
        chk("reset_resp_valid", 32'(resp_valid), 0);
        chk("reset_inflight", 32'(inflight), 0);
        chk("reset_req_ready", 32'(req_ready), 0);

        // Single op 1.0 + 1.0 on requester 0
        tick(); req_valid = 4'b0001; set_op(0, 16'h3C00, 16'h3C00);
        mid();  chk("single_grant", 32'(req_ready), 32'h1);
        tick(); req_valid = '0;
        mid();  chk("single_inflight_t1", 32'(inflight), 1);
                chk("single_no_early_resp", 32'(resp_valid), 0);
        tick();
        mid();  chk("single_resp_valid", 32'(resp_valid), 32'h1);
                chk("single_resp_c", 32'(resp_c[15:0]), 32'h4000);
        repeat (3) begin
            tick();
            mid(); chk("single_hold_c", 32'(resp_c[15:0]), 32'h4000);
                   chk("single_hold_inflight", 32'(inflight), 1);
        end
        tick(); resp_ready = 4'b0001;
        tick(); resp_ready = '0;
        mid();  chk("single_consumed_inflight", 32'(inflight), 0);
                chk("single_consumed_valid", 32'(resp_valid), 0);

        // Round-robin with every requester always asking and always consuming
        do_reset();
        req_valid = 4'b1111; resp_ready = 4'b1111;
        for (int i = 0; i < N; i++) set_op(i, rnd_half(), rnd_half());
        for (int j = 0; j < 12; j++) begin
            mid(); chk($sformatf("rr_order_%0d", j), 32'(grant_idx), j % 4);
                   chk($sformatf("rr_issue_%0d", j), 32'(|req_ready), 1);
            tick();
        end
        req_valid = '0;
        repeat (4) tick();

        // Routing: two ops back-to-back to different requesters
        do_reset();
        resp_ready = '0; req_valid = 4'b0010; set_op(1, 16'h3C00, 16'h4000);
        mid();  chk("route_grant1", 32'(req_ready), 32'h2);
        tick(); req_valid = 4'b0100; set_op(2, 16'h4000, 16'hBC00);
        mid();  chk("route_grant2", 32'(req_ready), 32'h4);
        tick(); req_valid = '0;
        tick();
        mid();  chk("route_valid", 32'(resp_valid), 32'h6);
                chk("route_c1", 32'(resp_c[31:16]), 32'h4200);
                chk("route_c2", 32'(resp_c[47:32]), 32'h3C00);
                chk("route_c0_clean", 32'(resp_c[15:0]), 0);
        tick(); resp_ready = 4'b0110;
        tick(); resp_ready = '0;

        // Backpressure on requester 3 while the others keep flowing
        req_valid = 4'b1000; set_op(3, 16'h4000, 16'h4000);
        mid();  chk("bp_grant3", 32'(req_ready), 32'h8);
        tick(); req_valid = '0;
        tick();
        req_valid = 4'b1111; resp_ready = 4'b0111;
        n_g = 0;
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < 3; i++) set_op(i, rnd_half(), rnd_half());
            mid(); chk("bp_ready3_low", 32'(req_ready[3]), 0);
                   chk("bp_c3_stable", 32'(resp_c[63:48]), 32'h4400);
                   chk("bp_valid3", 32'(resp_valid[3]), 1);
                   if (|req_ready) n_g++;
            tick();
        end
        chk("bp_others_served", n_g, 10);
        req_valid = 4'b1000; resp_ready = 4'b1111;
        mid();  chk("bp_release_same_cycle", 32'(req_ready[3]), 0);
        tick();
        mid();  chk("bp_regrant3", 32'(req_ready), 32'h8);
        tick(); req_valid = '0;
        repeat (4) tick();

        // Reset while two operations are in flight
        resp_ready = '0;
        req_valid = 4'b0001; set_op(0, 16'h3C00, 16'h3C00);
        tick(); req_valid = 4'b0010; set_op(1, 16'h4000, 16'h4000);
        tick(); req_valid = '0; rst = 1'b1;
        tick(); rst = 1'b0;
        for (int j = 0; j < 5; j++) begin
            mid(); chk("rst_mid_valid", 32'(resp_valid), 0);
                   chk("rst_mid_inflight", 32'(inflight), 0);
            tick();
        end
        req_valid = 4'b1111;
        mid();  chk("rst_ptr_restart", 32'(req_ready), 32'h1);
        tick(); req_valid = '0; resp_ready = 4'b1111;
        repeat (4) tick();

        // Idle with one held result; zero operand
        resp_ready = '0; req_valid = 4'b0100; set_op(2, 16'h0000, 16'h3C00);
        tick(); req_valid = '0;
        tick();
        for (int j = 0; j < 20; j++) begin
            mid(); chk("idle_ready", 32'(req_ready), 0);
                   chk("idle_valid", 32'(resp_valid), 32'h4);
                   chk("zero_plus_one", 32'(resp_c[47:32]), 32'h3C00);
            tick();
        end
        resp_ready = 4'b1111;
        tick();

        // Random traffic with occasional resets
        for (int j = 0; j < 1500; j++) begin
            rst        = ($urandom_range(199, 0) == 0);
            req_valid  = N'($urandom);
            resp_ready = N'($urandom);
            for (int i = 0; i < N; i++) set_op(i, rnd_half(), rnd_half());
            tick();
        end
        rst = 1'b0; req_valid = '0; resp_ready = '1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
